// File: rtl/aemb2_wbarb_pkg.sv
// Shared definitions for the AEMB2 instruction/data Wishbone arbiter.
package aemb2_wbarb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNTI = 2'd1,
        GNTD = 2'd2
    } arb_state_t;

    localparam logic [31:0] TMO_DAT = 32'hDEADDEAD;

endpackage

// File: rtl/aemb2_wbarb_tmo.sv
// Acknowledge timeout counter: cleared by clr, counts enabled cycles, and flags
// expiry in the cycle its count would reach all-ones (the 2^WIDTH-1'th cycle).
module aemb2_wbarb_tmo #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [WIDTH-1:0] LAST = {WIDTH{1'b1}} ^ WIDTH'(1);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign expire = en && (count == LAST);

endmodule

// File: rtl/aemb2_wbarb.sv
// Round-robin arbiter merging the AEMB2 iwb and dwb buses onto one shared
// Wishbone bus, with a sticky error flag when a slave fails to acknowledge.
module aemb2_wbarb
    import aemb2_wbarb_pkg::*;
#(
    parameter int AEMB_IWB = 32,
    parameter int AEMB_DWB = 32,
    parameter int AEMB_TMO = 8
) (
    input  logic                  sys_clk_i,
    input  logic                  sys_rst_i,

    input  logic [AEMB_IWB-1:2]   iwb_adr_i,
    input  logic                  iwb_stb_i,
    input  logic                  iwb_cyc_i,
    input  logic                  iwb_wre_i,
    input  logic                  iwb_tag_i,
    input  logic [3:0]            iwb_sel_i,
    output logic                  iwb_ack_o,
    output logic [31:0]           iwb_dat_o,

    input  logic [AEMB_DWB-1:2]   dwb_adr_i,
    input  logic                  dwb_stb_i,
    input  logic                  dwb_cyc_i,
    input  logic                  dwb_wre_i,
    input  logic                  dwb_tag_i,
    input  logic [3:0]            dwb_sel_i,
    input  logic [31:0]           dwb_dat_i,
    output logic                  dwb_ack_o,
    output logic [31:0]           dwb_dat_o,

    output logic [AEMB_DWB-1:2]   mwb_adr_o,
    output logic                  mwb_stb_o,
    output logic                  mwb_cyc_o,
    output logic                  mwb_wre_o,
    output logic                  mwb_tag_o,
    output logic [3:0]            mwb_sel_o,
    output logic [31:0]           mwb_dat_o,
    input  logic                  mwb_ack_i,
    input  logic [31:0]           mwb_dat_i,

    output logic                  arb_err_o
);

    arb_state_t state, state_next;
    logic       pri, pri_next;
    logic       err, err_next;

    logic       ireq, dreq;
    logic       gnt_i, gnt_d, gnt;
    logic       g_cyc;
    logic       ack, tmo_exp;
    logic [31:0] ack_dat;
    logic [AEMB_DWB-1:2] iadr_ext;

    assign ireq     = iwb_stb_i & iwb_cyc_i;
    assign dreq     = dwb_stb_i & dwb_cyc_i;
    assign gnt_i    = (state == GNTI);
    assign gnt_d    = (state == GNTD);
    assign gnt      = gnt_i | gnt_d;
    assign g_cyc    = gnt_i ? iwb_cyc_i : dwb_cyc_i;
    assign iadr_ext = (AEMB_DWB-2)'(iwb_adr_i);

    aemb2_wbarb_tmo #(
        .WIDTH (AEMB_TMO)
    ) u_tmo (
        .clk    (sys_clk_i),
        .rst    (sys_rst_i),
        .clr    (!gnt),
        .en     (gnt && g_cyc && !mwb_ack_i),
        .expire (tmo_exp)
    );

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state <= IDLE;
            pri   <= 1'b1;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            pri   <= pri_next;
            err   <= err_next;
        end
    end

    always_comb begin
        state_next = state;
        pri_next   = pri;
        err_next   = err;
        mwb_adr_o  = '0;
        mwb_stb_o  = 1'b0;
        mwb_cyc_o  = 1'b0;
        mwb_wre_o  = 1'b0;
        mwb_tag_o  = 1'b0;
        mwb_sel_o  = 4'b0000;
        mwb_dat_o  = 32'h0;
        ack        = 1'b0;
        ack_dat    = 32'h0;

        // Outputs are held low while reset is asserted, whatever the state.
        if (!sys_rst_i) begin
            case (state)
                IDLE: begin
                    if (ireq && (!dreq || !pri)) begin
                        state_next = GNTI;
                    end else if (dreq) begin
                        state_next = GNTD;
                    end
                end
                GNTI, GNTD: begin
                    if (gnt_i) begin
                        mwb_adr_o = iadr_ext;
                        mwb_stb_o = iwb_stb_i;
                        mwb_cyc_o = iwb_cyc_i;
                        mwb_wre_o = iwb_wre_i;
                        mwb_tag_o = iwb_tag_i;
                        mwb_sel_o = iwb_sel_i;
                    end else begin
                        mwb_adr_o = dwb_adr_i;
                        mwb_stb_o = dwb_stb_i;
                        mwb_cyc_o = dwb_cyc_i;
                        mwb_wre_o = dwb_wre_i;
                        mwb_tag_o = dwb_tag_i;
                        mwb_sel_o = dwb_sel_i;
                        mwb_dat_o = dwb_dat_i;
                    end

                    if (!g_cyc) begin
                        state_next = IDLE;
                    end else if (mwb_ack_i) begin
                        ack        = 1'b1;
                        ack_dat    = mwb_dat_i;
                        state_next = IDLE;
                        pri_next   = gnt_i;
                    end else if (tmo_exp) begin
                        ack        = 1'b1;
                        ack_dat    = TMO_DAT;
                        mwb_stb_o  = 1'b0;
                        mwb_cyc_o  = 1'b0;
                        err_next   = 1'b1;
                        state_next = IDLE;
                        pri_next   = gnt_i;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign iwb_ack_o = ack & gnt_i;
    assign dwb_ack_o = ack & gnt_d;
    assign iwb_dat_o = (ack & gnt_i) ? ack_dat : 32'h0;
    assign dwb_dat_o = (ack & gnt_d) ? ack_dat : 32'h0;
    assign arb_err_o = err;

endmodule

// File: tb/tb_aemb2_wbarb.sv
// Directed bench for aemb2_wbarb: vector table of single transactions plus
// hand-written sequences for round-robin order, timeout and reset abort.
module tb_aemb2_wbarb;

    localparam int IWB = 24;
    localparam int DWB = 32;
    localparam int TMO = 3;

    logic              sys_clk_i = 1'b0;
    logic              sys_rst_i;
    logic [IWB-1:2]    iwb_adr_i;
    logic              iwb_stb_i, iwb_cyc_i, iwb_wre_i, iwb_tag_i;
    logic [3:0]        iwb_sel_i;
    logic              iwb_ack_o;
    logic [31:0]       iwb_dat_o;
    logic [DWB-1:2]    dwb_adr_i;
    logic              dwb_stb_i, dwb_cyc_i, dwb_wre_i, dwb_tag_i;
    logic [3:0]        dwb_sel_i;
    logic [31:0]       dwb_dat_i;
    logic              dwb_ack_o;
    logic [31:0]       dwb_dat_o;
    logic [DWB-1:2]    mwb_adr_o;
    logic              mwb_stb_o, mwb_cyc_o, mwb_wre_o, mwb_tag_o;
    logic [3:0]        mwb_sel_o;
    logic [31:0]       mwb_dat_o;
    logic              mwb_ack_i;
    logic [31:0]       mwb_dat_i;
    logic              arb_err_o;

    aemb2_wbarb #(
        .AEMB_IWB (IWB),
        .AEMB_DWB (DWB),
        .AEMB_TMO (TMO)
    ) dut (
        .sys_clk_i (sys_clk_i),
        .sys_rst_i (sys_rst_i),
        .iwb_adr_i (iwb_adr_i),
        .iwb_stb_i (iwb_stb_i),
        .iwb_cyc_i (iwb_cyc_i),
        .iwb_wre_i (iwb_wre_i),
        .iwb_tag_i (iwb_tag_i),
        .iwb_sel_i (iwb_sel_i),
        .iwb_ack_o (iwb_ack_o),
        .iwb_dat_o (iwb_dat_o),
        .dwb_adr_i (dwb_adr_i),
        .dwb_stb_i (dwb_stb_i),
        .dwb_cyc_i (dwb_cyc_i),
        .dwb_wre_i (dwb_wre_i),
        .dwb_tag_i (dwb_tag_i),
        .dwb_sel_i (dwb_sel_i),
        .dwb_dat_i (dwb_dat_i),
        .dwb_ack_o (dwb_ack_o),
        .dwb_dat_o (dwb_dat_o),
        .mwb_adr_o (mwb_adr_o),
        .mwb_stb_o (mwb_stb_o),
        .mwb_cyc_o (mwb_cyc_o),
        .mwb_wre_o (mwb_wre_o),
        .mwb_tag_o (mwb_tag_o),
        .mwb_sel_o (mwb_sel_o),
        .mwb_dat_o (mwb_dat_o),
        .mwb_ack_i (mwb_ack_i),
        .mwb_dat_i (mwb_dat_i),
        .arb_err_o (arb_err_o)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    typedef struct {
        logic        ireq;
        logic        dreq;
        logic [21:0] iadr;
        logic [29:0] dadr;
        logic        dwre;
        logic [3:0]  dsel;
        logic [31:0] ddat;
        int          delay;
        logic [31:0] sdat;
        logic        port;     // 0 = iwb granted, 1 = dwb granted
        logic [29:0] eadr;
        logic        ewre;
        logic [3:0]  esel;
        logic [31:0] edat;
    } vec_t;

    int total = 0;
    int bad   = 0;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge sys_clk_i);
        #1;
    endtask

    task automatic settle;
        @(negedge sys_clk_i);
    endtask

    task automatic clear_inputs;
        iwb_adr_i = '0; iwb_stb_i = 0; iwb_cyc_i = 0; iwb_wre_i = 0; iwb_tag_i = 1; iwb_sel_i = 4'hF;
        dwb_adr_i = '0; dwb_stb_i = 0; dwb_cyc_i = 0; dwb_wre_i = 0; dwb_tag_i = 0; dwb_sel_i = 4'hF;
        dwb_dat_i = '0; mwb_ack_i = 0; mwb_dat_i = '0;
    endtask

    task automatic do_reset;
        clear_inputs();
        sys_rst_i = 1;
        tick();
        tick();
        sys_rst_i = 0;
    endtask

    task automatic set_ireq(input logic r, input logic [21:0] a);
        iwb_stb_i = r; iwb_cyc_i = r; iwb_adr_i = a;
    endtask

    task automatic set_dreq(input logic r, input logic [29:0] a);
        dwb_stb_i = r; dwb_cyc_i = r; dwb_adr_i = a;
    endtask

    initial begin
        //          ireq dreq iadr       dadr        wre  sel     ddat          dly sdat          port eadr          ewre esel    edat
        vecs[0] = '{1, 0, 22'h000100, 30'h0,      0, 4'hF,   32'h0,        2, 32'h12345678, 0, 30'h00000100, 0, 4'hF,   32'h0};
        vecs[1] = '{1, 1, 22'h000104, 30'h2000,   1, 4'b0011, 32'hCAFEF00D, 1, 32'h0,        1, 30'h00002000, 1, 4'b0011, 32'hCAFEF00D};
        vecs[2] = '{1, 1, 22'h3FFFFF, 30'h300,    0, 4'hF,   32'h0,        0, 32'hA5A5A5A5, 0, 30'h003FFFFF, 0, 4'hF,   32'h0};
        vecs[3] = '{1, 1, 22'h000200, 30'h304,    0, 4'b1100, 32'h0,        3, 32'h0BADF00D, 1, 30'h00000304, 0, 4'b1100, 32'h0};
        vecs[4] = '{0, 1, 22'h0,      30'h3FFFFFFF, 1, 4'b1000, 32'h87654321, 0, 32'h0,      1, 30'h3FFFFFFF, 1, 4'b1000, 32'h87654321};
        vecs[5] = '{1, 1, 22'h000208, 30'h400,    0, 4'hF,   32'h0,        1, 32'h11112222, 0, 30'h00000208, 0, 4'hF,   32'h0};
        vecs[6] = '{1, 0, 22'h00020C, 30'h0,      0, 4'hF,   32'h0,        4, 32'h33334444, 0, 30'h0000020C, 0, 4'hF,   32'h0};
        vecs[7] = '{1, 1, 22'h000210, 30'h500,    0, 4'b0001, 32'h0,        0, 32'h55556666, 1, 30'h00000500, 0, 4'b0001, 32'h0};

        // Reset state with requests pending, then ten idle cycles.
        clear_inputs();
        sys_rst_i = 1;
        set_ireq(1, 22'h10);
        set_dreq(1, 30'h20);
        settle();
        chk("rst_mwb_cyc", 32'(mwb_cyc_o), 32'd0);
        chk("rst_mwb_adr", 32'(mwb_adr_o), 32'd0);
        do_reset();
        for (int c = 0; c < 10; c++) begin
            settle();
            chk("idle_cyc", 32'(mwb_cyc_o), 32'd0);
            chk("idle_acks", {30'd0, iwb_ack_o, dwb_ack_o}, 32'd0);
            chk("idle_err", 32'(arb_err_o), 32'd0);
            tick();
        end

        // Table of single transactions; priority evolves from the reset value.
        for (int v = 0; v < 8; v++) begin
            set_ireq(vecs[v].ireq, vecs[v].iadr);
            set_dreq(vecs[v].dreq, vecs[v].dadr);
            dwb_wre_i = vecs[v].dwre;
            dwb_sel_i = vecs[v].dsel;
            dwb_dat_i = vecs[v].ddat;
            settle();
            chk("req_cycle_idle", 32'(mwb_cyc_o), 32'd0);
            tick();
            settle();
            chk("grant_cyc_stb", {30'd0, mwb_cyc_o, mwb_stb_o}, 32'd3);
            chk("grant_adr", 32'(mwb_adr_o), 32'(vecs[v].eadr));
            chk("grant_wre", 32'(mwb_wre_o), 32'(vecs[v].ewre));
            chk("grant_sel", 32'(mwb_sel_o), 32'(vecs[v].esel));
            chk("grant_dat", mwb_dat_o, vecs[v].edat);
            chk("grant_tag", 32'(mwb_tag_o), 32'(!vecs[v].port));
            for (int k = 0; k < vecs[v].delay; k++) begin
                chk("wait_acks", {30'd0, iwb_ack_o, dwb_ack_o}, 32'd0);
                tick();
                settle();
                chk("wait_adr", 32'(mwb_adr_o), 32'(vecs[v].eadr));
            end
            mwb_ack_i = 1;
            mwb_dat_i = vecs[v].sdat;
            #1;
            if (vecs[v].port) begin
                chk("d_ack", 32'(dwb_ack_o), 32'd1);
                chk("d_dat", dwb_dat_o, vecs[v].sdat);
                chk("i_ack_quiet", 32'(iwb_ack_o), 32'd0);
                chk("i_dat_quiet", iwb_dat_o, 32'd0);
            end else begin
                chk("i_ack", 32'(iwb_ack_o), 32'd1);
                chk("i_dat", iwb_dat_o, vecs[v].sdat);
                chk("d_ack_quiet", 32'(dwb_ack_o), 32'd0);
                chk("d_dat_quiet", dwb_dat_o, 32'd0);
            end
            tick();
            clear_inputs();
            settle();
            chk("post_ack_idle", {30'd0, mwb_cyc_o, iwb_ack_o | dwb_ack_o}, 32'd0);
            tick();
        end

        // Both requests held continuously from reset: D, I, D with an idle gap.
        do_reset();
        set_ireq(1, 22'h10);
        set_dreq(1, 30'h20);
        for (int g = 0; g < 3; g++) begin
            settle();
            chk("rr_gap_idle", 32'(mwb_cyc_o), 32'd0);
            tick();
            settle();
            chk("rr_adr", 32'(mwb_adr_o), (g == 1) ? 32'h10 : 32'h20);
            mwb_ack_i = 1;
            mwb_dat_i = 32'h100 + 32'(g);
            #1;
            chk("rr_ack_pair", {30'd0, iwb_ack_o, dwb_ack_o}, (g == 1) ? 32'd2 : 32'd1);
            tick();
            mwb_ack_i = 0;
        end
        clear_inputs();

        // Timeout with no slave ack: ack in 7th grant cycle, sticky error.
        do_reset();
        set_dreq(1, 30'h44);
        tick();
        for (int c = 1; c < 7; c++) begin
            settle();
            chk("tmo_wait_ack", {30'd0, iwb_ack_o, dwb_ack_o}, 32'd0);
            chk("tmo_wait_cyc", 32'(mwb_cyc_o), 32'd1);
            tick();
        end
        settle();
        chk("tmo_ack", 32'(dwb_ack_o), 32'd1);
        chk("tmo_dat", dwb_dat_o, 32'hDEADDEAD);
        chk("tmo_cyc_stb_drop", {30'd0, mwb_cyc_o, mwb_stb_o}, 32'd0);
        chk("tmo_i_quiet", 32'(iwb_ack_o), 32'd0);
        tick();
        clear_inputs();
        settle();
        chk("tmo_err_set", 32'(arb_err_o), 32'd1);
        chk("tmo_after_cyc", 32'(mwb_cyc_o), 32'd0);
        for (int c = 0; c < 4; c++) tick();
        settle();
        chk("tmo_err_sticky", 32'(arb_err_o), 32'd1);

        // Real ack in the expiry cycle wins: real data, no error.
        do_reset();
        settle();
        chk("err_cleared_by_rst", 32'(arb_err_o), 32'd0);
        set_ireq(1, 22'h48);
        tick();
        for (int c = 1; c < 7; c++) tick();
        settle();
        mwb_ack_i = 1;
        mwb_dat_i = 32'h55AA55AA;
        #1;
        chk("race_ack", 32'(iwb_ack_o), 32'd1);
        chk("race_dat", iwb_dat_o, 32'h55AA55AA);
        chk("race_cyc", 32'(mwb_cyc_o), 32'd1);
        tick();
        clear_inputs();
        settle();
        chk("race_no_err", 32'(arb_err_o), 32'd0);

        // Reset in the second GNTD cycle: cycle aborted, priority back to data.
        do_reset();
        set_dreq(1, 30'h80);
        tick();
        tick();
        settle();
        chk("midrst_cyc_before", 32'(mwb_cyc_o), 32'd1);
        sys_rst_i = 1;
        mwb_ack_i = 1;
        mwb_dat_i = 32'h1111;
        #1;
        chk("midrst_ack_gated", 32'(dwb_ack_o), 32'd0);
        tick();
        settle();
        chk("midrst_cyc", 32'(mwb_cyc_o), 32'd0);
        chk("midrst_ack", 32'(dwb_ack_o), 32'd0);
        sys_rst_i = 0;
        mwb_ack_i = 0;
        set_ireq(1, 22'h90);
        #1;
        chk("midrst_idle", 32'(mwb_cyc_o), 32'd0);
        tick();
        settle();
        chk("midrst_pri_d", 32'(mwb_adr_o), 32'h80);
        mwb_ack_i = 1;
        #1;
        chk("midrst_d_ack", 32'(dwb_ack_o), 32'd1);
        tick();
        clear_inputs();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aemb2_wbarb.md
Name: aemb2_wbarb

Overview:
- Two-into-one Wishbone classic arbiter placed directly downstream of the AEMB2 core.
- Merges the core's instruction bus (iwb) and data bus (dwb) onto one shared memory bus (mwb), so a single-ported SRAM or bridge can serve both.
- Round-robin arbitration, grant held for the whole bus cycle, and a per-cycle acknowledge timeout so a dead slave cannot hang the core.

Parameters:
- AEMB_IWB, 32, instruction address width; iwb_adr_i is [AEMB_IWB-1:2].
- AEMB_DWB, 32, data address width; dwb_adr_i and mwb_adr_o are [AEMB_DWB-1:2]; AEMB_DWB >= AEMB_IWB, iwb address zero-extended.
- AEMB_TMO, 8, timeout counter width; timeout fires after 2^AEMB_TMO-1 cycles without ack.

Ports:
- sys_clk_i  in  1  single clock, rising edge
- sys_rst_i  in  1  synchronous reset, active-high
- iwb_adr_i  in  AEMB_IWB-2  instruction address
- iwb_stb_i, iwb_cyc_i, iwb_wre_i, iwb_tag_i  in  1 each  instruction strobe/cycle/write/tag
- iwb_sel_i  in  4  instruction byte select
- iwb_ack_o  out  1  instruction acknowledge
- iwb_dat_o  out  32  instruction read data
- dwb_adr_i  in  AEMB_DWB-2  data address
- dwb_stb_i, dwb_cyc_i, dwb_wre_i, dwb_tag_i  in  1 each  data strobe/cycle/write/tag
- dwb_sel_i  in  4  data byte select
- dwb_dat_i  in  32  data write data
- dwb_ack_o  out  1  data acknowledge
- dwb_dat_o  out  32  data read data
- mwb_adr_o  out  AEMB_DWB-2  shared bus address
- mwb_stb_o, mwb_cyc_o, mwb_wre_o, mwb_tag_o  out  1 each  shared bus controls
- mwb_sel_o  out  4  shared bus byte select
- mwb_dat_o  out  32  shared bus write data
- mwb_ack_i  in  1  shared bus acknowledge
- mwb_dat_i  in  32  shared bus read data
- arb_err_o  out  1  sticky timeout flag, cleared only by reset

Behaviour:
- Request definitions: ireq = iwb_stb_i & iwb_cyc_i; dreq = dwb_stb_i & dwb_cyc_i.
- State register: IDLE, GNTI, GNTD, plus a 1-bit priority flag pri (0 = instruction preferred, 1 = data preferred).
- Reset: state IDLE, pri = 1, timeout counter 0, arb_err_o 0.
- Outputs during reset and in IDLE:
  - all mwb_* controls are 0 and mwb_adr_o/mwb_sel_o/mwb_dat_o are 0;
  - iwb_ack_o = dwb_ack_o = 0; iwb_dat_o = dwb_dat_o = 0.
- IDLE transitions:
  - only ireq -> GNTI; only dreq -> GNTD;
  - both -> GNTD if pri = 1, else GNTI;
  - neither -> stay IDLE.
- Arbitration latency: one cycle from request to mwb_stb_o.
- GNTx state:
  - mwb_* outputs combinationally follow the granted port (iwb_adr_i is zero-extended);
  - mwb_ack_i and mwb_dat_i are routed combinationally to the granted port only; the other port sees ack 0, dat 0.
- Leaving GNTx:
  - on mwb_ack_i = 1 -> IDLE next cycle and pri set to favour the other port;
  - if the granted requester drops cyc before ack (abort) -> IDLE, pri unchanged, no ack delivered.
- Back-to-back: one IDLE cycle always separates two grants, so the core can drop stb after ack. This costs one cycle of bandwidth and is intentional.
- Timeout:
  - counter cleared on entry to GNTx, increments each GNTx cycle without ack;
  - at all-ones it synthesises a one-cycle ack to the granted port with read data 0xDEADDEAD;
  - the same cycle sets arb_err_o, drops mwb_stb_o/mwb_cyc_o, then goes to IDLE;
  - a real mwb_ack_i arriving in the same cycle as timeout wins: real data, no error.
- mwb_ack_i in IDLE: ignored, not forwarded, not an error.
- Reset asserted mid-cycle: next edge forces IDLE with all outputs low; the slave sees cyc drop (legal Wishbone abort).

Decomposition:
- Shared package aemb2_wbarb_pkg holds:
  - the state encoding (IDLE=2'd0, GNTI=2'd1, GNTD=2'd2);
  - the timeout read-data constant 32'hDEADDEAD.
- One natural sub-module, aemb2_wbarb_tmo: the timeout counter with clear/enable inputs and an expiry output, reused later for the xwb path.

Test Plan:
- Reset then idle: both requests 0 for 10 cycles -> mwb_cyc_o = 0, acks 0, arb_err_o 0.
- Single iwb read:
  - stimulus: adr 0x100, slave acks on the 3rd cycle with 0x12345678;
  - response: mwb_adr_o = 0x100 one cycle after request, iwb_ack_o = 1 with iwb_dat_o = 0x12345678 in the ack cycle, dwb_ack_o stays 0.
- Simultaneous requests from reset:
  - stimulus: ireq and dreq both asserted;
  - response: dwb served first (pri = 1), one IDLE cycle, then iwb served; a third simultaneous pair goes to dwb.
- dwb write:
  - stimulus: sel 4'b0011, dat 0xCAFEF00D while iwb is also requesting;
  - response: mwb_wre_o = 1, mwb_sel_o = 4'b0011, mwb_dat_o = 0xCAFEF00D, iwb held off until the write ack.
- Timeout with AEMB_TMO = 3 and no slave ack:
  - response: ack delivered on the 7th grant cycle with data 0xDEADDEAD, arb_err_o = 1 and sticky;
  - ack and expiry in the same cycle: real data returned, arb_err_o stays 0.
- Reset mid-grant (cycle 2 of GNTD): next edge gives mwb_cyc_o = 0, state IDLE, pri = 1, and no spurious dwb_ack_o.
